// File: rtl/mci_mcu_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : mci_mcu_sram_arb
// Brief    : Locked round-robin arbiter sharing one MCU SRAM CIF port between
//            the AXI-sub decode path (req0) and the MCU-local/DMA path (req1).
// Revision : 1.0 - initial release
// ============================================================================
module mci_mcu_sram_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int UW        = 32,
    parameter int IW        = 8,
    parameter int MAX_GRANT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_dv,
    input  logic [AW-1:0]     req0_addr,
    input  logic              req0_write,
    input  logic [DW-1:0]     req0_wdata,
    input  logic [DW/8-1:0]   req0_wstrb,
    input  logic [UW-1:0]     req0_user,
    input  logic [IW-1:0]     req0_id,
    output logic              req0_hold,
    output logic [DW-1:0]     req0_rdata,
    output logic              req0_error,

    input  logic              req1_dv,
    input  logic [AW-1:0]     req1_addr,
    input  logic              req1_write,
    input  logic [DW-1:0]     req1_wdata,
    input  logic [DW/8-1:0]   req1_wstrb,
    input  logic [UW-1:0]     req1_user,
    input  logic [IW-1:0]     req1_id,
    output logic              req1_hold,
    output logic [DW-1:0]     req1_rdata,
    output logic              req1_error,

    output logic              sram_dv,
    output logic [AW-1:0]     sram_addr,
    output logic              sram_write,
    output logic [DW-1:0]     sram_wdata,
    output logic [DW/8-1:0]   sram_wstrb,
    output logic [UW-1:0]     sram_user,
    output logic [IW-1:0]     sram_id,
    input  logic              sram_hold,
    input  logic [DW-1:0]     sram_rdata,
    input  logic              sram_error,

    output logic [1:0]        arb_gnt
);

    localparam int              c_CW        = $clog2(MAX_GRANT + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(MAX_GRANT - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX   = c_CW'(MAX_GRANT);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT0 = 2'd1;
    localparam logic [1:0] c_GNT1 = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            r_prio;
    logic            w_prio_nxt;
    logic [1:0]      r_arb_gnt;

    logic            w_comp;
    logic            w_own_dv;
    logic            w_oth_dv;
    logic            w_oth_id;
    logic [1:0]      w_oth_state;

    assign w_comp      = sram_dv & ~sram_hold;
    assign w_own_dv    = (r_state == c_GNT1) ? req1_dv : req0_dv;
    assign w_oth_dv    = (r_state == c_GNT1) ? req0_dv : req1_dv;
    assign w_oth_id    = (r_state == c_GNT0);
    assign w_oth_state = w_oth_id ? c_GNT1 : c_GNT0;
    assign arb_gnt     = r_arb_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_prio    <= 1'b0;
            r_arb_gnt <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_prio    <= w_prio_nxt;
            r_arb_gnt <= {w_state_nxt == c_GNT1, w_state_nxt == c_GNT0};
        end
    end

    // The grant only moves when the owner is idle or a beat has just completed,
    // so a stalled beat is never pre-empted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_prio_nxt  = r_prio;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                if (req0_dv && req1_dv) begin
                    w_state_nxt = r_prio ? c_GNT1 : c_GNT0;
                end else if (req0_dv) begin
                    w_state_nxt = c_GNT0;
                end else if (req1_dv) begin
                    w_state_nxt = c_GNT1;
                end
            end
            c_GNT0, c_GNT1: begin
                if (!w_own_dv) begin
                    w_cnt_nxt = '0;
                    if (w_oth_dv) begin
                        w_state_nxt = w_oth_state;
                        w_prio_nxt  = w_oth_id;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else if (w_comp) begin
                    if (w_oth_dv && (r_cnt >= c_CNT_LAST)) begin
                        w_state_nxt = w_oth_state;
                        w_cnt_nxt   = '0;
                        w_prio_nxt  = w_oth_id;
                    end else if (r_cnt != c_CNT_MAX) begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        sram_dv    = 1'b0;
        sram_addr  = '0;
        sram_write = 1'b0;
        sram_wdata = '0;
        sram_wstrb = '0;
        sram_user  = '0;
        sram_id    = '0;
        req0_hold  = req0_dv;
        req0_rdata = '0;
        req0_error = 1'b0;
        req1_hold  = req1_dv;
        req1_rdata = '0;
        req1_error = 1'b0;
        case (r_state)
            c_GNT0: begin
                sram_dv    = req0_dv;
                sram_addr  = req0_addr;
                sram_write = req0_write;
                sram_wdata = req0_wdata;
                sram_wstrb = req0_wstrb;
                sram_user  = req0_user;
                sram_id    = req0_id;
                req0_hold  = sram_hold;
                req0_rdata = sram_rdata;
                req0_error = sram_error;
            end
            c_GNT1: begin
                sram_dv    = req1_dv;
                sram_addr  = req1_addr;
                sram_write = req1_write;
                sram_wdata = req1_wdata;
                sram_wstrb = req1_wstrb;
                sram_user  = req1_user;
                sram_id    = req1_id;
                req1_hold  = sram_hold;
                req1_rdata = sram_rdata;
                req1_error = sram_error;
            end
            default: begin
            end
        endcase
    end

    a_req0_stable: assert property (@(posedge clk) disable iff (rst)
        (req0_dv && req0_hold) |=> (req0_dv &&
            $stable({req0_addr, req0_write, req0_wdata, req0_wstrb, req0_user, req0_id})));

    a_req1_stable: assert property (@(posedge clk) disable iff (rst)
        (req1_dv && req1_hold) |=> (req1_dv &&
            $stable({req1_addr, req1_write, req1_wdata, req1_wstrb, req1_user, req1_id})));

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(arb_gnt));

    a_dv_granted: assert property (@(posedge clk) disable iff (rst) sram_dv |-> (r_state != c_IDLE));

endmodule
`default_nettype wire

// File: tb/tb_mci_mcu_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mci_mcu_sram_arb
// Brief    : Directed scenarios plus randomized traffic against a grant model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mci_mcu_sram_arb;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int UW        = 32;
    localparam int IW        = 8;
    localparam int SW        = DW / 8;
    localparam int MAX_GRANT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]    req_dv;
    logic [AW-1:0] req_addr  [2];
    logic [1:0]    req_write;
    logic [DW-1:0] req_wdata [2];
    logic [SW-1:0] req_wstrb [2];
    logic [UW-1:0] req_user  [2];
    logic [IW-1:0] req_id    [2];
    wire  [1:0]    req_hold;
    wire  [1:0]    req_error;
    wire  [DW-1:0] rdata0;
    wire  [DW-1:0] rdata1;

    wire           sram_dv;
    wire  [AW-1:0] sram_addr;
    wire           sram_write;
    wire  [DW-1:0] sram_wdata;
    wire  [SW-1:0] sram_wstrb;
    wire  [UW-1:0] sram_user;
    wire  [IW-1:0] sram_id;
    logic          sram_hold;
    logic [DW-1:0] sram_rdata;
    logic          sram_error;
    wire  [1:0]    arb_gnt;

    int checks = 0;
    int errors = 0;

    int m_owner;
    int m_beats;
    int m_prio;

    mci_mcu_sram_arb #(
        .AW(AW), .DW(DW), .UW(UW), .IW(IW), .MAX_GRANT(MAX_GRANT)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_dv(req_dv[0]), .req0_addr(req_addr[0]), .req0_write(req_write[0]),
        .req0_wdata(req_wdata[0]), .req0_wstrb(req_wstrb[0]), .req0_user(req_user[0]),
        .req0_id(req_id[0]), .req0_hold(req_hold[0]), .req0_rdata(rdata0), .req0_error(req_error[0]),
        .req1_dv(req_dv[1]), .req1_addr(req_addr[1]), .req1_write(req_write[1]),
        .req1_wdata(req_wdata[1]), .req1_wstrb(req_wstrb[1]), .req1_user(req_user[1]),
        .req1_id(req_id[1]), .req1_hold(req_hold[1]), .req1_rdata(rdata1), .req1_error(req_error[1]),
        .sram_dv(sram_dv), .sram_addr(sram_addr), .sram_write(sram_write), .sram_wdata(sram_wdata),
        .sram_wstrb(sram_wstrb), .sram_user(sram_user), .sram_id(sram_id),
        .sram_hold(sram_hold), .sram_rdata(sram_rdata), .sram_error(sram_error),
        .arb_gnt(arb_gnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req_dv    = '0;
        req_write = '0;
        for (int r = 0; r < 2; r++) begin
            req_addr[r]  = '0;
            req_wdata[r] = '0;
            req_wstrb[r] = '0;
            req_user[r]  = '0;
            req_id[r]    = '0;
        end
        sram_hold  = 1'b0;
        sram_rdata = '0;
        sram_error = 1'b0;
    endtask

    // Reference: who owns the port, how many beats they completed, who wins a tie.
    task automatic model_reset;
        m_owner = -1;
        m_beats = 0;
        m_prio  = 0;
    endtask

    task automatic model_tick;
        int n;
        int m;
        if (m_owner < 0) begin
            if (req_dv[0] && req_dv[1]) m_owner = m_prio;
            else if (req_dv[0])         m_owner = 0;
            else if (req_dv[1])         m_owner = 1;
            m_beats = 0;
        end else begin
            n = m_owner;
            m = 1 - n;
            if (!req_dv[n]) begin
                m_beats = 0;
                if (req_dv[m]) begin
                    m_owner = m;
                    m_prio  = m;
                end else begin
                    m_owner = -1;
                end
            end else if (!sram_hold) begin
                m_beats++;
                if (req_dv[m] && m_beats >= MAX_GRANT) begin
                    m_owner = m;
                    m_prio  = m;
                    m_beats = 0;
                end
            end
        end
    endtask

    task automatic test_reset;
        req_dv     = 2'b01;
        sram_hold  = 1'b1;
        sram_error = 1'b1;
        sram_rdata = 32'h1234_5678;
        #4;
        checks++; if (arb_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", arb_gnt); end
        checks++; if (sram_dv !== 1'b0) begin errors++; $display("FAIL reset_sram_dv: got %b expected 0", sram_dv); end
        checks++; if (req_hold !== 2'b01) begin errors++; $display("FAIL reset_hold: got %b expected 01", req_hold); end
        checks++; if (req_error !== 2'b00 || rdata0 !== '0) begin
            errors++; $display("FAIL reset_resp: got err=%b rdata0=%h expected err=00 rdata0=0", req_error, rdata0);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        tick();
        #4;
        checks++; if (arb_gnt !== 2'b00) begin errors++; $display("FAIL reset_idle_gnt: got %b expected 00", arb_gnt); end
        tick();
    endtask

    task automatic test_single_read;
        req_dv      = 2'b01;
        req_addr[0] = 32'h40;
        req_write   = 2'b00;
        sram_rdata  = 32'hDEAD_BEEF;
        #4;
        checks++; if (req_hold[0] !== 1'b1 || sram_dv !== 1'b0 || rdata0 !== '0) begin
            errors++; $display("FAIL rd_cycle0: got hold=%b sram_dv=%b rdata=%h expected 1 0 0", req_hold[0], sram_dv, rdata0);
        end
        tick();
        #4;
        checks++; if (sram_dv !== 1'b1 || sram_addr !== 32'h40 || req_hold[0] !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_cycle1: got dv=%b addr=%h hold=%b rdata=%h expected 1 40 0 deadbeef",
                               sram_dv, sram_addr, req_hold[0], rdata0);
        end
        checks++; if (arb_gnt !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b expected 01", arb_gnt); end
        tick();
        req_dv = 2'b00;
        #4;
        checks++; if (sram_dv !== 1'b0) begin errors++; $display("FAIL rd_cycle2_dv: got %b expected 0", sram_dv); end
        tick();
        #4;
        checks++; if (arb_gnt !== 2'b00) begin errors++; $display("FAIL rd_idle: got %b expected 00", arb_gnt); end
        tick();
    endtask

    task automatic test_tie;
        req_dv      = 2'b11;
        req_addr[0] = 32'h100;
        req_addr[1] = 32'h200;
        #4;
        checks++; if (req_hold !== 2'b11) begin errors++; $display("FAIL tie_cycle0_hold: got %b expected 11", req_hold); end
        tick();
        #4;
        checks++; if (arb_gnt !== 2'b01 || sram_addr !== 32'h100 || req_hold !== 2'b10) begin
            errors++; $display("FAIL tie_first: got gnt=%b addr=%h hold=%b expected 01 100 10", arb_gnt, sram_addr, req_hold);
        end
        tick();
        req_dv[0] = 1'b0;
        #4;
        checks++; if (req_hold[1] !== 1'b1) begin errors++; $display("FAIL tie_wait: got hold1=%b expected 1", req_hold[1]); end
        tick();
        #4;
        checks++; if (arb_gnt !== 2'b10 || sram_addr !== 32'h200 || req_hold[1] !== 1'b0) begin
            errors++; $display("FAIL tie_second: got gnt=%b addr=%h hold1=%b expected 10 200 0", arb_gnt, sram_addr, req_hold[1]);
        end
        tick();
        req_dv = 2'b00;
        tick();
    endtask

    task automatic test_fairness;
        logic [DW-1:0] wtab [2][16];
        logic [AW-1:0] base [2];
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [1:0]    adv;
        int            idx  [2];
        int            seen [2];
        int            k;
        int            cyc;
        int            er;
        base[0] = 32'h1000;
        base[1] = 32'h2000;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) wtab[r][i] = $urandom();
            idx[r]       = 0;
            seen[r]      = 0;
            req_addr[r]  = base[r];
            req_wdata[r] = wtab[r][0];
            req_wstrb[r] = '1;
        end
        req_write = 2'b11;
        sram_hold = 1'b0;
        k   = 0;
        cyc = 0;
        req_dv = 2'b01;
        while (req_dv != 2'b00 && cyc < 80) begin
            if (cyc == 1) req_dv[1] = 1'b1;
            #4;
            if (sram_dv && !sram_hold && k < 12) begin
                er = (k / 4) % 2;
                ea = base[er] + AW'(4 * seen[er]);
                ed = wtab[er][seen[er]];
                checks++; if (sram_addr !== ea || sram_wdata !== ed) begin
                    errors++; $display("FAIL fair_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                                       k, sram_addr, sram_wdata, ea, ed);
                end
                seen[er]++;
                k++;
            end
            adv = req_dv & ~req_hold;
            tick();
            cyc++;
            for (int r = 0; r < 2; r++) begin
                if (adv[r]) begin
                    if (k >= 12) begin
                        req_dv[r] = 1'b0;
                    end else begin
                        idx[r]++;
                        req_addr[r]  = base[r] + AW'(4 * idx[r]);
                        req_wdata[r] = wtab[r][idx[r]];
                    end
                end
            end
        end
        checks++; if (k != 12 || req_dv != 2'b00) begin
            errors++; $display("FAIL fair_timeout: got %0d beats expected 12", k);
        end
        req_dv = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_stall;
        req_dv       = 2'b10;
        req_addr[1]  = 32'h300;
        req_wdata[1] = 32'hA5A5_A5A5;
        req_write    = 2'b10;
        tick();
        req_dv[0]   = 1'b1;
        req_addr[0] = 32'h50;
        sram_hold   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++; if (arb_gnt !== 2'b10 || req_hold !== 2'b11 || sram_addr !== 32'h300 ||
                          sram_wdata !== 32'hA5A5_A5A5 || sram_write !== 1'b1) begin
                errors++; $display("FAIL stall_c%0d: got gnt=%b hold=%b addr=%h data=%h expected 10 11 300 a5a5a5a5",
                                   i, arb_gnt, req_hold, sram_addr, sram_wdata);
            end
            tick();
        end
        sram_hold = 1'b0;
        #4;
        checks++; if (arb_gnt !== 2'b10 || req_hold !== 2'b01) begin
            errors++; $display("FAIL stall_complete: got gnt=%b hold=%b expected 10 01", arb_gnt, req_hold);
        end
        tick();
        req_dv[1] = 1'b0;
        #4;
        checks++; if (arb_gnt !== 2'b10) begin errors++; $display("FAIL stall_after: got %b expected 10", arb_gnt); end
        tick();
        #4;
        checks++; if (arb_gnt !== 2'b01 || sram_addr !== 32'h50) begin
            errors++; $display("FAIL stall_switch: got gnt=%b addr=%h expected 01 50", arb_gnt, sram_addr);
        end
        tick();
        req_dv = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_error;
        req_dv      = 2'b01;
        req_addr[0] = 32'h80;
        sram_error  = 1'b1;
        #4;
        checks++; if (req_error !== 2'b00) begin errors++; $display("FAIL err_idle: got %b expected 00", req_error); end
        tick();
        #4;
        checks++; if (req_error !== 2'b01) begin errors++; $display("FAIL err_comp: got %b expected 01", req_error); end
        tick();
        req_dv     = 2'b00;
        sram_error = 1'b0;
        #4;
        checks++; if (req_error !== 2'b00) begin errors++; $display("FAIL err_after: got %b expected 00", req_error); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        req_dv      = 2'b10;
        req_addr[1] = 32'h700;
        tick();
        sram_hold = 1'b1;
        #2;
        checks++; if (arb_gnt !== 2'b10 || sram_dv !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: got gnt=%b dv=%b expected 10 1", arb_gnt, sram_dv);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (arb_gnt !== 2'b00 || sram_dv !== 1'b0 || req_hold !== 2'b10) begin
            errors++; $display("FAIL rmid_async: got gnt=%b dv=%b hold=%b expected 00 0 10", arb_gnt, sram_dv, req_hold);
        end
        tick();
        rst         = 1'b0;
        sram_hold   = 1'b0;
        req_dv[0]   = 1'b1;
        req_addr[0] = 32'h60;
        tick();
        #4;
        checks++; if (arb_gnt !== 2'b01 || sram_addr !== 32'h60 || req_hold[1] !== 1'b1) begin
            errors++; $display("FAIL rmid_tie: got gnt=%b addr=%h hold1=%b expected 01 60 1", arb_gnt, sram_addr, req_hold[1]);
        end
        tick();
        req_dv[0] = 1'b0;
        tick();
        #4;
        checks++; if (arb_gnt !== 2'b10 || req_hold[1] !== 1'b0) begin
            errors++; $display("FAIL rmid_next: got gnt=%b hold1=%b expected 10 0", arb_gnt, req_hold[1]);
        end
        tick();
        req_dv = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_random;
        logic [1:0]    e_gnt;
        logic          e_dv;
        logic [1:0]    e_hold;
        logic [1:0]    e_err;
        logic [DW-1:0] e_rd [2];
        logic [AW+DW+SW+UW+IW:0] e_fld;
        logic [AW+DW+SW+UW+IW:0] a_fld;
        logic [1:0]    done;
        rst = 1'b1;
        clear_inputs();
        tick();
        model_reset();
        rst = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_dv[r] && $urandom_range(2) == 0) begin
                    req_dv[r]    = 1'b1;
                    req_addr[r]  = $urandom();
                    req_write[r] = 1'($urandom_range(1));
                    req_wdata[r] = $urandom();
                    req_wstrb[r] = SW'($urandom());
                    req_user[r]  = $urandom();
                    req_id[r]    = IW'($urandom());
                end
            end
            sram_hold  = ($urandom_range(3) == 0);
            sram_error = 1'($urandom_range(1));
            sram_rdata = $urandom();
            #4;
            e_gnt   = 2'b00;
            e_dv    = 1'b0;
            e_fld   = '0;
            e_hold  = req_dv;
            e_err   = 2'b00;
            e_rd[0] = '0;
            e_rd[1] = '0;
            if (m_owner >= 0) begin
                e_gnt           = (m_owner == 0) ? 2'b01 : 2'b10;
                e_dv            = req_dv[m_owner];
                e_fld           = {req_addr[m_owner], req_write[m_owner], req_wdata[m_owner],
                                   req_wstrb[m_owner], req_user[m_owner], req_id[m_owner]};
                e_hold[m_owner] = sram_hold;
                e_err[m_owner]  = sram_error;
                e_rd[m_owner]   = sram_rdata;
            end
            a_fld = {sram_addr, sram_write, sram_wdata, sram_wstrb, sram_user, sram_id};
            checks++; if (arb_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt@%0d: got %b expected %b", cyc, arb_gnt, e_gnt); end
            checks++; if (sram_dv !== e_dv) begin errors++; $display("FAIL rnd_dv@%0d: got %b expected %b", cyc, sram_dv, e_dv); end
            checks++; if (a_fld !== e_fld) begin errors++; $display("FAIL rnd_fields@%0d: got %h expected %h", cyc, a_fld, e_fld); end
            checks++; if (req_hold !== e_hold) begin errors++; $display("FAIL rnd_hold@%0d: got %b expected %b", cyc, req_hold, e_hold); end
            checks++; if (req_error !== e_err) begin errors++; $display("FAIL rnd_err@%0d: got %b expected %b", cyc, req_error, e_err); end
            checks++; if (rdata0 !== e_rd[0] || rdata1 !== e_rd[1]) begin
                errors++; $display("FAIL rnd_rdata@%0d: got %h/%h expected %h/%h", cyc, rdata0, rdata1, e_rd[0], e_rd[1]);
            end
            done = req_dv & ~e_hold;
            model_tick();
            tick();
            req_dv = req_dv & ~done;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_tie();
        test_fairness();
        test_stall();
        test_error();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
